// File: rtl/one_wire_deserializer.sv
// one_wire_deserializer
//   Rebuilds a 64-bit 1-Wire ROM frame (56-bit UID, family code in bits 7:0,
//   followed by the Maxim CRC byte) from an LSB-first serial bit stream. The
//   Dallas/Maxim CRC-8 is accumulated over the UID bits as they arrive and
//   compared against the received CRC byte when the frame completes.
//
// Ports
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   i_frame_start   synchronous frame (re)start, priority over i_bit_valid
//   i_bit_valid     qualifies i_bit_in for one cycle
//   i_bit_in        serial data, UID LSB first, then CRC LSB first
//   o_uid_data      last completed UID (held until the next completion)
//   o_crc_rx        last received CRC byte (held)
//   o_crc_ok        computed CRC matched o_crc_rx (held)
//   o_uid_valid     one-cycle pulse when new results are published
//   o_busy          a frame is in progress
//   o_frame_abort   one-cycle pulse when a partial frame is discarded
module one_wire_deserializer #(
    parameter int UID_SERIAL_DATA_WIDTH = 56,
    parameter int CRC_WIDTH             = 8,
    parameter int CNT_WIDTH             = 7
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_frame_start,
    input  logic                             i_bit_valid,
    input  logic                             i_bit_in,
    output logic [UID_SERIAL_DATA_WIDTH-1:0] o_uid_data,
    output logic [CRC_WIDTH-1:0]             o_crc_rx,
    output logic                             o_crc_ok,
    output logic                             o_uid_valid,
    output logic                             o_busy,
    output logic                             o_frame_abort
);

    localparam int UW = UID_SERIAL_DATA_WIDTH;
    localparam int CW = CRC_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_UID_BIT = CNT_WIDTH'(UW - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT     = CNT_WIDTH'(UW + CW - 1);
    // Reflected form of x^8+x^5+x^4+1
    localparam logic [CW-1:0]        CRC_POLY     = CW'(8'h8C);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UID  = 2'd1,
        S_CRC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [UW-1:0]         r_shift;
    logic [CW-1:0]         r_crc_shift;
    logic [CW-1:0]         r_crc_acc;
    logic [UW-1:0]         r_uid_data;
    logic [CW-1:0]         r_crc_rx;
    logic                  r_crc_ok;
    logic                  r_uid_valid;
    logic                  r_busy;
    logic                  r_frame_abort;
    logic                  w_in_frame;

    function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? CRC_POLY : '0);
    endfunction

    assign w_in_frame = (r_state == S_UID) || (r_state == S_CRC);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_frame_start) w_next_state = S_UID;
            end
            S_UID: begin
                if (i_frame_start)
                    w_next_state = S_UID;
                else if (i_bit_valid && (r_cnt == LAST_UID_BIT))
                    w_next_state = S_CRC;
            end
            S_CRC: begin
                if (i_frame_start)
                    w_next_state = S_UID;
                else if (i_bit_valid && (r_cnt == LAST_BIT))
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = i_frame_start ? S_UID : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_crc_shift   <= '0;
            r_crc_acc     <= '0;
            r_uid_data    <= '0;
            r_crc_rx      <= '0;
            r_crc_ok      <= 1'b0;
            r_uid_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // A restart wins over a same-cycle bit, which then becomes bit 0
            // of the new frame on a freshly cleared CRC.
            if (i_frame_start) begin
                r_crc_shift <= '0;
                if (i_bit_valid) begin
                    r_cnt     <= CNT_WIDTH'(1);
                    r_shift   <= {i_bit_in, {(UW-1){1'b0}}};
                    r_crc_acc <= crc_step('0, i_bit_in);
                end else begin
                    r_cnt     <= '0;
                    r_shift   <= '0;
                    r_crc_acc <= '0;
                end
            end else if (i_bit_valid) begin
                // Right-shifting LSB-first data leaves bit 0 at position 0
                // once the field is full.
                if (r_state == S_UID) begin
                    r_shift   <= {i_bit_in, r_shift[UW-1:1]};
                    r_crc_acc <= crc_step(r_crc_acc, i_bit_in);
                    r_cnt     <= r_cnt + CNT_WIDTH'(1);
                end else if (r_state == S_CRC) begin
                    r_crc_shift <= {i_bit_in, r_crc_shift[CW-1:1]};
                    r_cnt       <= r_cnt + CNT_WIDTH'(1);
                end
            end

            // Publish from the frame registers before any same-edge restart
            // clears them.
            r_uid_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_uid_data <= r_shift;
                r_crc_rx   <= r_crc_shift;
                r_crc_ok   <= (r_crc_acc == r_crc_shift);
            end

            r_frame_abort <= i_frame_start && w_in_frame;
            // Registered from both current and next state so busy rises the
            // cycle after a start and falls one cycle after DONE is left.
            r_busy        <= (r_state != S_IDLE) || (w_next_state != S_IDLE);
        end
    end

    assign o_uid_data    = r_uid_data;
    assign o_crc_rx      = r_crc_rx;
    assign o_crc_ok      = r_crc_ok;
    assign o_uid_valid   = r_uid_valid;
    assign o_busy        = r_busy;
    assign o_frame_abort = r_frame_abort;

endmodule

// File: tb/tb_one_wire_deserializer.sv
// Testbench for one_wire_deserializer: table of frames (fixed and random)
// checked against a byte-wise CRC-8 reference, plus hand-written sequences
// for sparse strobes, abort, mid-frame reset and back-to-back frames.
module tb_one_wire_deserializer;

    localparam int UW = 56;
    localparam int CW = 8;
    localparam logic [UW-1:0] GOOD_UID = 56'h00000001B81C02;
    localparam logic [CW-1:0] GOOD_CRC = 8'hA2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fs = 1'b0;
    logic          bv = 1'b0;
    logic          bi = 1'b0;
    logic [UW-1:0] uid_data;
    logic [CW-1:0] crc_rx;
    logic          crc_ok;
    logic          uid_valid;
    logic          busy;
    logic          frame_abort;

    one_wire_deserializer #(
        .UID_SERIAL_DATA_WIDTH(UW),
        .CRC_WIDTH(CW),
        .CNT_WIDTH(7)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_frame_start(fs),
        .i_bit_valid(bv),
        .i_bit_in(bi),
        .o_uid_data(uid_data),
        .o_crc_rx(crc_rx),
        .o_crc_ok(crc_ok),
        .o_uid_valid(uid_valid),
        .o_busy(busy),
        .o_frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge
    int cyc = 0;
    int n_valid = 0;
    int n_abort = 0;
    int n_busy_low = 0;
    int t_valid[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uid_valid) begin
            n_valid++;
            t_valid.push_back(cyc);
        end
        if (frame_abort) n_abort++;
        if (!busy) n_busy_low++;
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC: byte-at-a-time reflected CRC-8/MAXIM over the 7 UID bytes
    function automatic logic [7:0] model_crc(input logic [UW-1:0] uid);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < UW / 8; k++) begin
            c = c ^ uid[8*k +: 8];
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    // mode 0: frame_start alone, then bits; 1: frame_start with bit 0; 2: bits only
    task automatic send_frame(input logic [UW-1:0] uid, input logic [CW-1:0] crc,
                              input int max_gap, input int mode);
        if (mode == 0) begin
            fs = 1'b1;
            tick();
            fs = 1'b0;
        end
        for (int i = 0; i < UW + CW; i++) begin
            bv = 1'b1;
            bi = (i < UW) ? uid[i] : crc[i-UW];
            if (i == 0 && mode == 1) fs = 1'b1;
            tick();
            bv = 1'b0;
            fs = 1'b0;
            bi = 1'b0;
            if (max_gap > 0 && i < UW + CW - 1)
                repeat ($urandom_range(max_gap, 0)) tick();
        end
    endtask

    // Called right after the edge that accepted bit 63
    task automatic check_result(input string tag, input logic [UW-1:0] uid,
                                input logic [CW-1:0] crc, input logic ok);
        chk({tag, "_valid_not_early"}, 64'(uid_valid), 64'd0);
        tick();
        chk({tag, "_valid_pulse"}, 64'(uid_valid), 64'd1);
        chk({tag, "_uid_data"}, 64'(uid_data), 64'(uid));
        chk({tag, "_crc_rx"}, 64'(crc_rx), 64'(crc));
        chk({tag, "_crc_ok"}, 64'(crc_ok), 64'(ok));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        tick();
        chk({tag, "_valid_single"}, 64'(uid_valid), 64'd0);
        chk({tag, "_busy_falls"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [UW-1:0] uid;
        logic [CW-1:0] crc;
        int            max_gap;
        logic [UW-1:0] exp_uid;
        logic [CW-1:0] exp_crc;
        logic          exp_ok;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [63:0]   r64;
        logic [UW-1:0] u;
        logic [UW-1:0] u1;
        logic [UW-1:0] u2;
        logic [CW-1:0] c;
        int a0, v0, b0, tv, gap;

        vecs[0] = '{GOOD_UID, GOOD_CRC, 0, GOOD_UID, GOOD_CRC, 1'b1};
        vecs[1] = '{GOOD_UID, 8'hA3,    0, GOOD_UID, 8'hA3,    1'b0};
        for (int i = 2; i < 6; i++) begin
            r64 = {$urandom(), $urandom()};
            u = r64[UW-1:0];
            case (i)
                2, 3:    c = model_crc(u);
                4:       c = model_crc(u) ^ (8'h01 << $urandom_range(7, 0));
                default: c = 8'($urandom());
            endcase
            vecs[i] = '{u, c, (i % 2 == 1) ? 5 : 0, u, c, (c == model_crc(u))};
        end

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_uid_data", 64'(uid_data), 64'd0);
        chk("reset_crc_rx", 64'(crc_rx), 64'd0);
        chk("reset_flags", 64'({crc_ok, uid_valid, busy, frame_abort}), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].uid, vecs[i].crc, vecs[i].max_gap, 0);
            check_result($sformatf("vec%0d", i), vecs[i].exp_uid, vecs[i].exp_crc, vecs[i].exp_ok);
        end

        // Sparse strobes, with bit_valid pulses in IDLE first
        v0 = n_valid;
        repeat (5) begin
            bv = 1'b1;
            bi = 1'($urandom());
            tick();
            bv = 1'b0;
            tick();
        end
        chk("idle_bits_busy", 64'(busy), 64'd0);
        chk("idle_bits_no_valid", 64'(n_valid - v0), 64'd0);
        send_frame(GOOD_UID, GOOD_CRC, 20, 0);
        check_result("sparse", GOOD_UID, GOOD_CRC, 1'b1);

        // Abort after 30 bits
        a0 = n_abort;
        fs = 1'b1;
        tick();
        fs = 1'b0;
        r64 = {$urandom(), $urandom()};
        for (int i = 0; i < 30; i++) begin
            bv = 1'b1;
            bi = r64[i];
            tick();
            bv = 1'b0;
        end
        fs = 1'b1;
        tick();
        fs = 1'b0;
        chk("abort_pulse", 64'(frame_abort), 64'd1);
        chk("abort_uid_held", 64'(uid_data), 64'(GOOD_UID));
        chk("abort_crc_ok_held", 64'(crc_ok), 64'd1);
        tick();
        chk("abort_pulse_single", 64'(frame_abort), 64'd0);
        chk("abort_count", 64'(n_abort - a0), 64'd1);
        send_frame(GOOD_UID, GOOD_CRC, 0, 1);
        check_result("restart_bit0", GOOD_UID, GOOD_CRC, 1'b1);

        // Asynchronous reset after 40 bits
        fs = 1'b1;
        tick();
        fs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bv = 1'b1;
            bi = GOOD_UID[i];
            tick();
            bv = 1'b0;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_uid_data", 64'(uid_data), 64'd0);
        chk("rst_mid_crc_rx", 64'(crc_rx), 64'd0);
        chk("rst_mid_flags", 64'({crc_ok, uid_valid, busy, frame_abort}), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        v0 = n_valid;
        for (int i = 0; i < 24; i++) begin
            bv = 1'b1;
            bi = 1'($urandom());
            tick();
            bv = 1'b0;
        end
        repeat (3) tick();
        chk("rst_mid_no_valid", 64'(n_valid - v0), 64'd0);
        chk("rst_mid_idle", 64'(busy), 64'd0);

        // Back-to-back: restart in the DONE cycle, one idle cycle, second frame
        r64 = {$urandom(), $urandom()};
        u1 = r64[UW-1:0];
        r64 = {$urandom(), $urandom()};
        u2 = r64[UW-1:0];
        v0 = n_valid;
        tv = t_valid.size();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        b0 = n_busy_low;
        send_frame(u1, model_crc(u1), 0, 2);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        chk("b2b_first_valid", 64'(uid_valid), 64'd1);
        chk("b2b_first_uid", 64'(uid_data), 64'(u1));
        chk("b2b_first_ok", 64'(crc_ok), 64'd1);
        tick();
        send_frame(u2, model_crc(u2), 0, 2);
        chk("b2b_busy_held", 64'(n_busy_low - b0), 64'd0);
        check_result("b2b_second", u2, model_crc(u2), 1'b1);
        chk("b2b_pulses", 64'(n_valid - v0), 64'd2);
        gap = (t_valid.size() >= tv + 2) ? (t_valid[tv+1] - t_valid[tv]) : -1;
        chk("b2b_spacing", 64'(gap), 64'd66);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/one_wire_deserializer.md
# one_wire_deserializer

Receive-side counterpart of the 1-Wire UID serializer. Accepts an LSB-first serial bit stream, one bit per `bit_valid` strobe, and reassembles a 64-bit ROM frame: a 56-bit UID (family code in bits 7:0) followed by an 8-bit Maxim CRC byte. The CRC is computed on the fly and the result is presented to the data controller with a one-cycle `uid_valid` pulse. It sits between the 1-Wire bit-level slot decoder and the data controller.

## Interface
- `UID_SERIAL_DATA_WIDTH`, 56: UID bits per frame.
- `CRC_WIDTH`, 8: CRC bits per frame, received after the UID. The CRC polynomial is fixed at 8 bits.
- `CNT_WIDTH`, 7: bit counter width; must hold `UID_SERIAL_DATA_WIDTH + CRC_WIDTH` (64).
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `frame_start` input 1: synchronous frame (re)start.
- `bit_valid` input 1: qualifies `bit_in` for one cycle.
- `bit_in` input 1: serial data, LSB of the UID first.
- `uid_data` output `UID_SERIAL_DATA_WIDTH`: assembled UID.
- `crc_rx` output `CRC_WIDTH`: received CRC byte.
- `crc_ok` output 1: the computed CRC over the UID equals `crc_rx`.
- `uid_valid` output 1: one-cycle pulse when the frame is complete.
- `busy` output 1: a frame is in progress.
- `frame_abort` output 1: one-cycle pulse when a frame in progress is discarded by `frame_start`.

## Operation
- **States:** IDLE, UID, CRC, DONE.
- **IDLE:**
  - `bit_valid` is ignored.
  - `frame_start` moves to UID, clears the bit counter, clears the shift register, and clears the CRC accumulator to 8'h00.
- **UID:**
  - On each `bit_valid`, `bit_in` is written into UID position `cnt` (LSB-first), and the counter increments.
  - The CRC is updated on each UID bit: `fb = crc[0] ^ bit_in`, then `crc = (crc >> 1) ^ (fb ? 8'h8C : 8'h00)`. This is the Dallas/Maxim polynomial x^8+x^5+x^4+1.
  - Accepting bit 55 moves to CRC.
- **CRC:**
  - On each `bit_valid`, `bit_in` is written into `crc_rx` position `cnt-56`, LSB-first. The CRC accumulator is not updated.
  - Accepting bit 63 moves to DONE.
- **DONE (one cycle):**
  - `uid_data` and `crc_rx` are loaded from the internal registers.
  - `crc_ok` = (accumulator == received byte).
  - `uid_valid` = 1.
  - Next state is IDLE.
- **Output hold:** `uid_data`, `crc_rx` and `crc_ok` hold until the next DONE. They do not change during a later frame in progress.
- **`busy`:** high in UID, CRC and DONE.
- **`frame_start` in UID or CRC:**
  - Partial frame discarded.
  - `frame_abort` pulses the next cycle.
  - Restart in UID with the counter, shift register and CRC cleared.
  - Published outputs are unchanged.
- **`frame_start` in DONE:** DONE completes normally (`uid_valid` still pulses). Next state is UID (cleared), not IDLE.
- **`frame_start` and `bit_valid` in the same cycle:** `frame_start` has priority. The same-cycle `bit_in` is taken as bit 0 of the new frame and fed into the freshly cleared CRC.
- **`bit_valid` in DONE:** ignored.
- **Reset values:** on `rst_n` low, at any time including mid-frame, all state returns to IDLE. All outputs go to 0: `uid_data`=0, `crc_rx`=0, `crc_ok`=0, `uid_valid`=0, `busy`=0, `frame_abort`=0.

## Timing
- Every output is registered; there is no combinational path from input to output.
- `busy` rises the cycle after `frame_start`.
- Latency: if bit 63 is accepted at edge N, DONE is entered at edge N, and `uid_valid`/`uid_data`/`crc_ok` update at edge N+1. They are visible in cycle N+1 to N+2, and `uid_valid` is high for exactly that cycle.
- `busy` falls at edge N+2, unless a restart occurred in DONE.
- Back-to-back `bit_valid` (every cycle) is supported. Minimum frame time is 64 cycles plus 2.
- Gaps between `bit_valid` strobes are unbounded. The block has no timeout.
- `frame_abort` is a single-cycle pulse, one edge after the `frame_start` that caused it.

## Test plan
- **Good frame:** `frame_start`, then 64 bits LSB-first of UID 56'h00000001B81C02 and CRC 8'hA2 on consecutive cycles. Required: one `uid_valid` pulse 1 cycle after the last bit, `uid_data`=56'h00000001B81C02, `crc_rx`=8'hA2, `crc_ok`=1, `busy` low 2 cycles after the last bit.
- **Corrupted CRC:** same frame with CRC byte 8'hA3. Required: `uid_valid` pulses, `crc_rx`=8'hA3, `crc_ok`=0, `uid_data` correct.
- **Sparse strobes:** good frame with random 0–20 idle cycles between `bit_valid` strobes, plus `bit_valid` pulses in IDLE before `frame_start`. Required: identical result to the good-frame case; the pre-start bits are ignored.
- **Abort:**
  - Step 1: `frame_start` after 30 bits of a frame. Required: `frame_abort` pulses once; previous `uid_data` is unchanged.
  - Step 2: a full good frame, sent with its bit 0 in the same cycle as `frame_start`. Required: correct UID and `crc_ok`=1.
- **Reset mid-frame:** assert `rst_n`=0 asynchronously after 40 bits, between clock edges. Required: all outputs 0 immediately. After release, 24 further `bit_valid` strobes produce no `uid_valid`.
- **Back-to-back:** two good frames, with `frame_start` asserted in the DONE cycle of the first. Required: two `uid_valid` pulses 66 cycles apart, and `busy` stays high throughout.
